// File: rtl/program_loader.sv
// program_loader: streams a header (base, count) plus payload into CPU memory and holds the CPU in reset until loaded.
// Define PROGRAM_LOADER_VERIFY_EN to add a readback checksum pass (VERIFY state, load_err).
module program_loader #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              memrq,
  output logic              rnw,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [DATA_W-1:0] ONE_D = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [HW-1:0]     ONE_H = 1;
  localparam logic [HW-1:0]     HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [2:0] {IDLE, HDR_ADDR, HDR_CNT, WRITE, VERIFY, HOLD, RUN, ERROR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] wr_cnt;
  logic [HW-1:0]     hold_cnt;
  logic              accept;
  logic              last_wr;

  assign accept  = in_valid && in_ready;
  assign last_wr = (wr_cnt == count - ONE_D);

`ifdef PROGRAM_LOADER_VERIFY_EN
  logic [DATA_W-1:0] checksum;
  logic [DATA_W-1:0] rd_sum;
  logic [DATA_W-1:0] rd_cnt;
  logic [DATA_W-1:0] rx_cnt;
  logic [DATA_W-1:0] sum_next;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ret;

  assign sum_next = rd_sum + mem_rdata;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign load_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      memrq     <= 1'b0;
      rnw       <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
      base      <= '0;
      wr_addr   <= '0;
      count     <= '0;
      wr_cnt    <= '0;
      hold_cnt  <= '0;
`ifdef PROGRAM_LOADER_VERIFY_EN
      load_err  <= 1'b0;
      checksum  <= '0;
      rd_sum    <= '0;
      rd_cnt    <= '0;
      rx_cnt    <= '0;
      rd_addr   <= '0;
      rd_ret    <= 1'b0;
`endif
    end else begin
      memrq <= 1'b0;
`ifdef PROGRAM_LOADER_VERIFY_EN
      // Read data arrives the cycle after the request strobe.
      rd_ret <= memrq && rnw;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR_ADDR;
            in_ready <= 1'b1;
          end
        end
        HDR_ADDR: begin
          if (accept) begin
            base  <= in_data[ADDR_W-1:0];
            state <= HDR_CNT;
          end
        end
        HDR_CNT: begin
          if (accept) begin
            count    <= in_data;
            wr_addr  <= base;
            wr_cnt   <= '0;
            hold_cnt <= '0;
`ifdef PROGRAM_LOADER_VERIFY_EN
            checksum <= '0;
`endif
            if (in_data == '0) begin
              state    <= HOLD;
              in_ready <= 1'b0;
            end else begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (accept) begin
            memrq     <= 1'b1;
            rnw       <= 1'b0;
            mem_addr  <= wr_addr;
            mem_wdata <= in_data;
            wr_addr   <= wr_addr + ONE_A;
            wr_cnt    <= wr_cnt + ONE_D;
`ifdef PROGRAM_LOADER_VERIFY_EN
            checksum  <= checksum + in_data;
`endif
            if (last_wr) begin
              in_ready <= 1'b0;
`ifdef PROGRAM_LOADER_VERIFY_EN
              state    <= VERIFY;
              rd_addr  <= base;
              rd_cnt   <= '0;
              rx_cnt   <= '0;
              rd_sum   <= '0;
`else
              state    <= HOLD;
`endif
            end
          end
        end
`ifdef PROGRAM_LOADER_VERIFY_EN
        VERIFY: begin
          // The final write strobe occupies the first VERIFY cycle; reads follow it.
          if (rd_cnt != count) begin
            memrq    <= 1'b1;
            rnw      <= 1'b1;
            mem_addr <= rd_addr;
            rd_addr  <= rd_addr + ONE_A;
            rd_cnt   <= rd_cnt + ONE_D;
          end
          if (rd_ret) begin
            rd_sum <= sum_next;
            rx_cnt <= rx_cnt + ONE_D;
            if (rx_cnt == count - ONE_D) begin
              if (sum_next == checksum) begin
                state <= HOLD;
              end else begin
                state    <= ERROR;
                load_err <= 1'b1;
              end
            end
          end
        end
`endif
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            cpu_rst_n <= 1'b1;
            load_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + ONE_H;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: header/payload loads, gaps, address wrap, zero count, mid-load reset, verify error.
module tb_program_loader;
  localparam int RST_HOLD = 4;
`ifdef PROGRAM_LOADER_VERIFY_EN
  localparam int VERIFY = 1;
`else
  localparam int VERIFY = 0;
`endif

  logic        clk, rst, start, in_valid, in_ready, memrq, rnw, cpu_rst_n, load_done, load_err;
  logic [15:0] in_data, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;
  int          compared, mismatched, cyc, rise_cyc;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;
  wr_t         wr_log[$];
  logic [11:0] rd_log[$];
  logic [15:0] mem [4096];
  logic        corrupt_en;
  logic [11:0] corrupt_addr;

  program_loader #(.DATA_W(16), .ADDR_W(12), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .memrq(memrq), .rnw(rnw), .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory, optionally flipping a bit on readback of one address.
  always @(posedge clk) begin
    if (memrq && !rnw) mem[mem_addr] <= mem_wdata;
    if (memrq && rnw)
      mem_rdata <= mem[mem_addr] ^ ((corrupt_en && mem_addr == corrupt_addr) ? 16'h0100 : 16'h0000);
  end

  always @(negedge clk) begin
    if (rst) begin
      wr_log.delete();
      rd_log.delete();
      rise_cyc = -1;
    end else begin
      if (memrq && !rnw) wr_log.push_back('{mem_addr, mem_wdata, cyc});
      if (memrq && rnw) rd_log.push_back(mem_addr);
      if (cpu_rst_n && rise_cyc < 0) rise_cyc = cyc;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0; corrupt_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge just after the word was accepted.
  task automatic push_word(input logic [15:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [11:0] base, input int cnt, input logic [15:0] pay [8],
                         input bit gap, output int hdr_cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push_word({4'h0, base});
    push_word(16'(cnt));
    hdr_cyc = cyc;
    for (int k = 0; k < cnt; k++) begin
      push_word(pay[k]);
      if (gap && k < cnt - 1) @(negedge clk);
    end
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(load_done || load_err) && n < 300) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (!(load_done || load_err)) begin
      mismatched++;
      $display("FAIL %s_timeout: done=%0b err=%0b required completion", name, load_done, load_err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int seen;
    apply_reset();
    compared++;
    if ({in_ready, memrq, rnw, cpu_rst_n, load_done, load_err} !== 6'b001000) begin
      mismatched++;
      $display("FAIL reset_ctrl: rdy/rq/rnw/cpu/done/err=%06b required 001000",
               {in_ready, memrq, rnw, cpu_rst_n, load_done, load_err});
    end
    compared++;
    if (mem_addr !== 12'h000 || mem_wdata !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_bus: addr=%h wdata=%h required 000/0000", mem_addr, mem_wdata);
    end
    seen = 0;
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    repeat (4) begin
      @(negedge clk);
      if (in_ready || memrq) seen++;
    end
    in_valid = 1'b0;
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL idle_ignores_valid: %0d active cycles required 0", seen);
    end
  endtask

  task automatic test_basic();
    logic [15:0] pay [8];
    int hc, last;
    pay = '{16'h0015, 16'h2016, 16'h2017, 16'h2018, 16'h2019, 16'h201A, 16'h7000, 16'h0000};
    apply_reset();
    do_load(12'h000, 7, pay, 1'b0, hc);
    wait_end("basic");
    compared++;
    if (wr_log.size() !== 7) begin
      mismatched++;
      $display("FAIL basic_count: %0d writes required 7", wr_log.size());
    end
    for (int k = 0; k < wr_log.size() && k < 7; k++) begin
      compared++;
      if (wr_log[k].addr !== 12'(k) || wr_log[k].data !== pay[k] || wr_log[k].cyc !== wr_log[0].cyc + k) begin
        mismatched++;
        $display("FAIL basic_write%0d: addr=%h data=%h dcyc=%0d required %h/%h/%0d", k, wr_log[k].addr,
                 wr_log[k].data, wr_log[k].cyc - wr_log[0].cyc, 12'(k), pay[k], k);
      end
    end
    last = (wr_log.size() > 0) ? wr_log[wr_log.size()-1].cyc : -1000;
    compared++;
    if (rise_cyc - last !== RST_HOLD + VERIFY * 9) begin
      mismatched++;
      $display("FAIL basic_rise: %0d cycles required %0d", rise_cyc - last, RST_HOLD + VERIFY * 9);
    end
    compared++;
    if ({load_done, load_err, cpu_rst_n} !== 3'b101) begin
      mismatched++;
      $display("FAIL basic_status: done/err/cpu=%03b required 101", {load_done, load_err, cpu_rst_n});
    end
    compared++;
    if (rd_log.size() !== VERIFY * 7) begin
      mismatched++;
      $display("FAIL basic_reads: %0d reads required %0d", rd_log.size(), VERIFY * 7);
    end
    for (int k = 0; k < rd_log.size(); k++) begin
      compared++;
      if (rd_log[k] !== 12'(k)) begin
        mismatched++;
        $display("FAIL basic_read%0d: addr=%h required %h", k, rd_log[k], 12'(k));
      end
    end
  endtask

  task automatic test_gaps();
    logic [15:0] pay [8];
    logic [15:0] sum;
    int hc, last;
    pay = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd0, 16'd0};
    apply_reset();
    do_load(12'd21, 6, pay, 1'b1, hc);
    wait_end("gaps");
    compared++;
    if (wr_log.size() !== 6) begin
      mismatched++;
      $display("FAIL gaps_count: %0d writes required 6", wr_log.size());
    end
    sum = 16'h0;
    for (int k = 0; k < wr_log.size() && k < 6; k++) begin
      sum += wr_log[k].data;
      compared++;
      if (wr_log[k].addr !== 12'(21 + k) || wr_log[k].data !== 16'(10 + k) ||
          wr_log[k].cyc !== wr_log[0].cyc + 2 * k) begin
        mismatched++;
        $display("FAIL gaps_write%0d: addr=%0d data=%0d dcyc=%0d required %0d/%0d/%0d", k, wr_log[k].addr,
                 wr_log[k].data, wr_log[k].cyc - wr_log[0].cyc, 21 + k, 10 + k, 2 * k);
      end
    end
    compared++;
    if (sum !== 16'h004B) begin
      mismatched++;
      $display("FAIL gaps_checksum: %h required 004b", sum);
    end
    last = (wr_log.size() > 0) ? wr_log[wr_log.size()-1].cyc : -1000;
    compared++;
    if (rise_cyc - last !== RST_HOLD + VERIFY * 8) begin
      mismatched++;
      $display("FAIL gaps_rise: %0d cycles required %0d", rise_cyc - last, RST_HOLD + VERIFY * 8);
    end
    compared++;
    if ({load_done, load_err} !== 2'b10) begin
      mismatched++;
      $display("FAIL gaps_status: done/err=%02b required 10", {load_done, load_err});
    end
  endtask

  task automatic test_wrap();
    logic [15:0] pay [8];
    logic [11:0] exp_a [4];
    int hc;
    pay   = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
    exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    apply_reset();
    do_load(12'hFFE, 4, pay, 1'b0, hc);
    wait_end("wrap");
    compared++;
    if (wr_log.size() !== 4 || rd_log.size() !== VERIFY * 4) begin
      mismatched++;
      $display("FAIL wrap_count: %0d writes %0d reads required 4/%0d", wr_log.size(), rd_log.size(), VERIFY * 4);
    end
    for (int k = 0; k < wr_log.size() && k < 4; k++) begin
      compared++;
      if (wr_log[k].addr !== exp_a[k] || wr_log[k].data !== pay[k]) begin
        mismatched++;
        $display("FAIL wrap_write%0d: addr=%h data=%h required %h/%h", k, wr_log[k].addr, wr_log[k].data,
                 exp_a[k], pay[k]);
      end
    end
    for (int k = 0; k < rd_log.size() && k < 4; k++) begin
      compared++;
      if (rd_log[k] !== exp_a[k]) begin
        mismatched++;
        $display("FAIL wrap_read%0d: addr=%h required %h", k, rd_log[k], exp_a[k]);
      end
    end
    compared++;
    if ({load_done, load_err} !== 2'b10) begin
      mismatched++;
      $display("FAIL wrap_status: done/err=%02b required 10", {load_done, load_err});
    end
  endtask

  task automatic test_zero();
    logic [15:0] pay [8];
    int hc;
    pay = '{default: 16'h0};
    apply_reset();
    do_load(12'h123, 0, pay, 1'b0, hc);
    wait_end("zero");
    compared++;
    if (wr_log.size() !== 0 || rd_log.size() !== 0) begin
      mismatched++;
      $display("FAIL zero_strobes: %0d writes %0d reads required 0/0", wr_log.size(), rd_log.size());
    end
    compared++;
    if (rise_cyc - hc !== RST_HOLD) begin
      mismatched++;
      $display("FAIL zero_rise: %0d cycles required %0d", rise_cyc - hc, RST_HOLD);
    end
    compared++;
    if ({load_done, cpu_rst_n} !== 2'b11) begin
      mismatched++;
      $display("FAIL zero_status: done/cpu=%02b required 11", {load_done, cpu_rst_n});
    end
  endtask

`ifdef PROGRAM_LOADER_VERIFY_EN
  task automatic test_verify_error();
    logic [15:0] pay [8];
    int hc, highs;
    pay = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h0, 16'h0, 16'h0};
    apply_reset();
    corrupt_en   = 1'b1;
    corrupt_addr = 12'h202;
    do_load(12'h200, 5, pay, 1'b0, hc);
    wait_end("verr");
    compared++;
    if ({load_err, load_done, cpu_rst_n} !== 3'b100) begin
      mismatched++;
      $display("FAIL verr_status: err/done/cpu=%03b required 100", {load_err, load_done, cpu_rst_n});
    end
    highs = 0;
    repeat (100) begin
      @(negedge clk);
      if (cpu_rst_n || load_done || !load_err) highs++;
    end
    compared++;
    if (highs !== 0) begin
      mismatched++;
      $display("FAIL verr_hold: %0d bad cycles required 0", highs);
    end
    corrupt_en = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    logic [15:0] pay [8];
    int hc, seen;
    pay = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'h0, 16'h0};
    apply_reset();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push_word(16'h0040);
    push_word(16'd6);
    for (int k = 0; k < 3; k++) push_word(pay[k]);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    @(negedge clk);
    compared++;
    if ({in_ready, memrq, rnw, cpu_rst_n, load_done, load_err} !== 6'b001000 ||
        mem_addr !== 12'h000 || mem_wdata !== 16'h0000) begin
      mismatched++;
      $display("FAIL midrst_outputs: ctrl=%06b addr=%h wdata=%h required 001000/000/0000",
               {in_ready, memrq, rnw, cpu_rst_n, load_done, load_err}, mem_addr, mem_wdata);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (memrq) seen++;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL midrst_strobes: %0d strobes required 0", seen);
    end
    do_load(12'h300, 6, pay, 1'b0, hc);
    wait_end("midrst_reload");
    compared++;
    if (wr_log.size() !== 6) begin
      mismatched++;
      $display("FAIL midrst_count: %0d writes required 6", wr_log.size());
    end
    for (int k = 0; k < wr_log.size() && k < 6; k++) begin
      compared++;
      if (wr_log[k].addr !== 12'(12'h300 + k) || wr_log[k].data !== pay[k]) begin
        mismatched++;
        $display("FAIL midrst_write%0d: addr=%h data=%h required %h/%h", k, wr_log[k].addr, wr_log[k].data,
                 12'(12'h300 + k), pay[k]);
      end
    end
    compared++;
    if ({load_done, load_err, cpu_rst_n} !== 3'b101) begin
      mismatched++;
      $display("FAIL midrst_status: done/err/cpu=%03b required 101", {load_done, load_err, cpu_rst_n});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0; corrupt_en = 1'b0; corrupt_addr = 12'h0;
    compared = 0; mismatched = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_wrap();
    test_zero();
`ifdef PROGRAM_LOADER_VERIFY_EN
    test_verify_error();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/program_loader.md
# program_loader

Hardware boot loader placed between a word-stream source and the CPU's program/data memory. After `start`, it accepts a header (base address, word count) and a payload over a valid/ready stream, writes each word into memory through the memrq/rnw port, and holds the CPU in reset until loading completes. It is the parametrised, synthesisable successor to bench-side memory preloading: any width, any address space, and any load length, with optional readback verification.

## Interface
- `DATA_W`, 16, memory word width; also the stream width.
- `ADDR_W`, 12, memory address width.
- `RST_HOLD`, 4, cycles `cpu_rst_n` stays low after load completes (≥1).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a load from IDLE.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_data`  in  DATA_W  stream word.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid 1 cycle after a read request.
- `memrq`  out  1  memory request strobe.
- `rnw`  out  1  1 = read, 0 = write.
- `cpu_rst_n`  out  1  CPU reset, active-low.
- `load_done`  out  1  level; load finished without error.
- `load_err`  out  1  level; verify mismatch (only with verify compiled in).

## Operation
- States: IDLE, HDR_ADDR, HDR_CNT, WRITE, VERIFY (macro only), HOLD, RUN, ERROR.
- IDLE: `in_ready`=0. `start`=1 → HDR_ADDR. `start` is ignored in every other state.
- HDR_ADDR: `in_ready`=1. On accept, base = `in_data[ADDR_W-1:0]` (upper bits ignored) → HDR_CNT.
- HDR_CNT: `in_ready`=1. On accept, count = `in_data`. Count 0 → HOLD. Otherwise → WRITE.
- WRITE: `in_ready`=1. Each accepted word k (0-based) is written to (base+k) mod 2^ADDR_W. The checksum accumulates `in_data` mod 2^DATA_W. After the count-th accept → VERIFY if compiled in, else HOLD.
- VERIFY: issues count sequential reads from base, one per cycle, with wrap-around. It sums `mem_rdata` mod 2^DATA_W. After the last read data returns: sum equal to checksum → HOLD, else → ERROR.
- HOLD: counts RST_HOLD cycles → RUN.
- RUN: `cpu_rst_n`=1, `load_done`=1. It stays in RUN until `rst`.
- ERROR: `load_err`=1, `cpu_rst_n`=0. It stays in ERROR until `rst`.
- `in_ready` is 0 in IDLE, VERIFY, HOLD, RUN and ERROR. `in_valid` there is ignored and has no side effects.

## Timing
- Reset values: state IDLE, `in_ready`=0, `memrq`=0, `rnw`=1, `mem_addr`=0, `mem_wdata`=0, `cpu_rst_n`=0, `load_done`=0, `load_err`=0. Checksum and counters are 0.
- `rst` asserted in any state, including mid-WRITE or mid-VERIFY, returns to the reset values on the next edge. No further memory request is issued after that edge.
- Accept = `in_valid && in_ready` at edge N. For a payload word, `memrq`=1, `rnw`=0, `mem_addr`, `mem_wdata` are registered and valid during cycle N+1, for exactly one cycle.
- Throughput is one word per cycle. Gaps in `in_valid` produce gaps in `memrq`. Write order equals accept order.
- VERIFY read requests use `memrq`=1, `rnw`=1 on consecutive cycles. `mem_rdata` for the request in cycle M is sampled at the end of cycle M+1.
- The state leaves WRITE at the edge of the last accept. The last write strobe appears in the first cycle of the following state.
- `cpu_rst_n` rises RST_HOLD cycles after HOLD entry and is registered, so it is glitch-free. `load_done` rises in the same cycle.
- Count arithmetic is DATA_W wide. A count larger than 2^ADDR_W wraps and overwrites earlier addresses; this is legal and is not flagged.

## Configuration
- `PROGRAM_LOADER_VERIFY_EN` defined: VERIFY state, readback logic and `load_err` are present.
- Not defined: WRITE → HOLD directly. `load_err` is tied to 0. No read requests are ever issued, so `rnw` is 0 whenever `memrq`=1.

## Test plan
- Base 0, count 7, payload 0x0015, 0x2016, 0x2017, 0x2018, 0x2019, 0x201A, 0x7000, continuous valid -> seven write strobes on consecutive cycles at addresses 0..6. `cpu_rst_n` rises RST_HOLD cycles after HOLD entry (plus verify time if enabled). `load_done`=1.
- Base 21, count 6, payload 10..15, with `in_valid` dropped every other cycle -> writes at 21..26 with matching gaps. Checksum 75 (0x004B). Verify passes.
- Base 0xFFE, count 4, payload 1..4 -> writes at 0xFFE, 0xFFF, 0x000, 0x001. Verify reads wrap identically.
- Count 0 -> no `memrq` strobe. HDR_CNT → HOLD. `cpu_rst_n` rises RST_HOLD cycles later.
- Verify enabled, memory model corrupts address base+2 on readback -> ERROR state, `load_err`=1, `cpu_rst_n` stays 0 for 100 cycles.
- `rst` asserted after 3 of 6 payload words -> next cycle: `memrq`=0, all outputs at reset values. A fresh `start` plus a full load then completes normally.
